// File: rtl/alu_result_serializer_pkg.sv
// Shared types, constants and checksum helpers for the ALU result serializer.
// The CRC function is also used by verification to predict control packets.
package alu_result_serializer_pkg;

  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CMD  = 1'b1
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } ser_state_e;

  // Bit positions inside req_err_flags and req_alu_flags
  localparam int ERR_DATA      = 2;
  localparam int ERR_CRC       = 1;
  localparam int ERR_OP        = 0;
  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 0;

  localparam int PKT_BITS    = 11;
  localparam int RESULT_PKTS = 5;
  localparam logic [5:0] RESULT_LAST_BIT = 6'(PKT_BITS * RESULT_PKTS - 1);
  localparam logic [5:0] ERROR_LAST_BIT  = 6'(PKT_BITS - 1);

  // CRC-3 (x^3+x+1) over {C, 1'b0, flags}, MSB first, zero seed
  function automatic logic [2:0] crc3_calc(input logic [31:0] c, input logic [3:0] flags);
    logic [36:0] msg;
    logic [2:0]  crc;
    logic        fb;
    msg = {c, 1'b0, flags};
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return crc;
  endfunction

  function automatic logic err_parity(input logic [2:0] ef);
    return ^{1'b1, ef, ef};
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// Request handshake plus serial line between an ALU response source and the serializer.
interface alu_result_serializer_if;
  import alu_result_serializer_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_error;
  logic [31:0] req_c;
  logic [3:0]  req_alu_flags;
  logic [2:0]  req_err_flags;
  logic        sout;
  logic        busy;

  modport master (
    output req_valid, req_error, req_c, req_alu_flags, req_err_flags,
    input  req_ready, sout, busy
  );

  modport slave (
    input  req_valid, req_error, req_c, req_alu_flags, req_err_flags,
    output req_ready, sout, busy
  );

endinterface

// File: rtl/alu_result_serializer_tx_bit_timer.sv
// Bit-period timer: while enabled, pulses o_tick on the last clock of every BIT_CYCLES window.
module alu_tx_bit_timer
  import alu_result_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);

  logic [7:0] r_cnt;

  assign o_tick = i_en && (r_cnt == 8'(BIT_CYCLES - 1));

  // Counter parks at zero when disabled so every response starts a fresh bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (!i_en || o_tick) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Serializes a captured ALU result (4 data packets + control) or an error packet onto sout.
// Packets are 11 bits {start 0, type, payload MSB first, stop 1}, sent back-to-back.
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  alu_result_serializer_if.slave  bus
);

  ser_state_e  r_state;
  logic        r_ready;
  logic        r_busy;
  logic        r_sout;
  logic        r_error;
  logic [31:0] r_c;
  logic [3:0]  r_flags;
  logic [2:0]  r_err_flags;
  logic [5:0]  r_bit_cnt;
  logic [2:0]  r_pkt_cnt;

  logic        w_tick;
  logic        w_xfer;
  logic        w_last;
  logic        w_next_bit;
  pkt_type_e   w_type;
  logic [3:0]  w_pos;
  logic [3:0]  w_nxt_pos;
  logic [2:0]  w_nxt_pkt;
  logic [2:0]  w_crc;
  logic [7:0]  w_payload;

  alu_tx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == ST_SEND),
    .o_tick (w_tick)
  );

  // r_ready is only ever set in IDLE, so it alone qualifies the handshake
  assign w_xfer = bus.req_valid && r_ready;
  assign w_crc  = crc3_calc(r_c, r_flags);
  assign w_last = r_error ? (r_bit_cnt == ERROR_LAST_BIT) : (r_bit_cnt == RESULT_LAST_BIT);

  assign w_pos     = 4'(r_bit_cnt - 6'd11 * {3'b000, r_pkt_cnt});
  assign w_nxt_pos = (w_pos == 4'd10) ? 4'd0 : w_pos + 4'd1;
  assign w_nxt_pkt = (w_pos == 4'd10) ? r_pkt_cnt + 3'd1 : r_pkt_cnt;

  // Value of the bit that follows the one currently on sout
  always_comb begin
    w_type     = PKT_DATA;
    w_payload  = 8'h00;
    w_next_bit = 1'b1;
    if (r_error) begin
      w_type    = PKT_CMD;
      w_payload = {1'b1,
                   r_err_flags[ERR_DATA], r_err_flags[ERR_CRC], r_err_flags[ERR_OP],
                   r_err_flags[ERR_DATA], r_err_flags[ERR_CRC], r_err_flags[ERR_OP],
                   err_parity(r_err_flags)};
    end else begin
      case (w_nxt_pkt)
        3'd0:    w_payload = r_c[31:24];
        3'd1:    w_payload = r_c[23:16];
        3'd2:    w_payload = r_c[15:8];
        3'd3:    w_payload = r_c[7:0];
        default: begin
          w_type    = PKT_CMD;
          w_payload = {1'b0,
                       r_flags[FLAG_CARRY], r_flags[FLAG_OVERFLOW],
                       r_flags[FLAG_ZERO], r_flags[FLAG_NEGATIVE],
                       w_crc};
        end
      endcase
    end
    case (w_nxt_pos)
      4'd0:    w_next_bit = 1'b0;
      4'd1:    w_next_bit = w_type;
      4'd10:   w_next_bit = 1'b1;
      default: w_next_bit = w_payload[3'(4'd9 - w_nxt_pos)];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_sout      <= 1'b1;
      r_error     <= 1'b0;
      r_c         <= 32'd0;
      r_flags     <= 4'd0;
      r_err_flags <= 3'd0;
      r_bit_cnt   <= 6'd0;
      r_pkt_cnt   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_error     <= bus.req_error;
            r_c         <= bus.req_c;
            r_flags     <= bus.req_alu_flags;
            r_err_flags <= bus.req_err_flags;
            r_bit_cnt   <= 6'd0;
            r_pkt_cnt   <= 3'd0;
            r_sout      <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SEND;
          end else begin
            r_sout  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (w_tick) begin
            if (w_last) begin
              r_sout  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
              r_pkt_cnt <= w_nxt_pkt;
              r_sout    <= w_next_bit;
            end
          end
        end
        ST_DONE: begin
          r_sout  <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_sout  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.sout      = r_sout;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed and randomized checks of alu_result_serializer at BIT_CYCLES 1 and 4.
module tb_alu_result_serializer;
  import alu_result_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_serializer_if ifa ();
  alu_result_serializer_if ifb ();

  alu_result_serializer #(.BIT_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  alu_result_serializer #(.BIT_CYCLES(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  localparam logic [54:0] EXP_ZERO     = {11'h001, 11'h001, 11'h001, 11'h001, 11'h22D};
  localparam logic [54:0] EXP_12345678 = {11'h025, 11'h069, 11'h0AD, 11'h0F1, 11'h20D};
  localparam logic [54:0] EXP_ONE      = {11'h001, 11'h001, 11'h001, 11'h003, 11'h205};
  localparam logic [10:0] EXP_ERR001   = 11'h327;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [54:0] bits;
  logic [54:0] exp_bits;
  int          busy_c;
  int          rdy_c;
  logic        idle_ok;
  logic        first_b;
  logic        stable_b;
  logic        bitv;
  int          k;
  logic        r_err;
  logic [31:0] r_c;
  logic [3:0]  r_fl;
  logic [2:0]  r_ef;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frm(input logic t, input logic [7:0] p);
    return {1'b0, t, p, 1'b1};
  endfunction

  // Present a request on ifa and complete the handshake; returns just after the transfer edge
  task automatic xfer_a(input logic err, input logic [31:0] c, input logic [3:0] fl,
                        input logic [2:0] ef, input logic hold);
    int w;
    w = 0;
    ifa.req_valid     = 1'b1;
    ifa.req_error     = err;
    ifa.req_c         = c;
    ifa.req_alu_flags = fl;
    ifa.req_err_flags = ef;
    while (!ifa.req_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("xfer_ready", 64'(ifa.req_ready), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) ifa.req_valid = 1'b0;
  endtask

  // Receive one response on ifa, sampling each cycle until req_ready returns
  task automatic cap_a(input int nbits, output logic [54:0] rx, output int nbusy,
                       output int nrdy, output logic idle_hi);
    rx      = '1;
    nbusy   = 0;
    nrdy    = -1;
    idle_hi = 1'b1;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      if (j <= nbits) rx[55 - j] = ifa.sout;
      else if (ifa.sout !== 1'b1) idle_hi = 1'b0;
      if (ifa.busy) nbusy++;
      if (ifa.req_ready) begin
        nrdy = j;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.req_valid = 1'b0; ifa.req_error = 1'b0; ifa.req_c = '0;
    ifa.req_alu_flags = '0; ifa.req_err_flags = '0;
    ifb.req_valid = 1'b0; ifb.req_error = 1'b0; ifb.req_c = '0;
    ifb.req_alu_flags = '0; ifb.req_err_flags = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sout", 64'(ifa.sout), 64'd1);
    chk("rst_ready", 64'(ifa.req_ready), 64'd0);
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_sout_b", 64'(ifb.sout), 64'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(ifa.req_ready), 64'd1);
    chk("busy_after_rst", 64'(ifa.busy), 64'd0);

    // All-zero result, flags 0010
    xfer_a(1'b0, 32'h0000_0000, 4'b0010, 3'b000, 1'b0);
    cap_a(55, bits, busy_c, rdy_c, idle_ok);
    chk("zero_bits", 64'(bits), 64'(EXP_ZERO));
    chk("zero_ready_cyc", 64'(rdy_c), 64'd57);
    chk("zero_busy_cyc", 64'(busy_c), 64'd56);
    chk("zero_idle", 64'(idle_ok), 64'd1);

    // Error packet, err_flags 001
    xfer_a(1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b001, 1'b0);
    cap_a(11, bits, busy_c, rdy_c, idle_ok);
    chk("err_bits", 64'(bits[54:44]), 64'(EXP_ERR001));
    chk("err_busy_cyc", 64'(busy_c), 64'd12);
    chk("err_ready_cyc", 64'(rdy_c), 64'd13);
    chk("err_idle", 64'(idle_ok), 64'd1);

    // BIT_CYCLES=4 instance, inputs scrambled after transfer
    ifb.req_valid = 1'b1; ifb.req_error = 1'b0; ifb.req_c = 32'h1234_5678;
    ifb.req_alu_flags = 4'b0000; ifb.req_err_flags = 3'b000;
    k = 0;
    while (!ifb.req_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("b_ready", 64'(ifb.req_ready), 64'd1);
    @(posedge clk);
    #1;
    ifb.req_valid = 1'b0; ifb.req_c = 32'hFFFF_FFFF; ifb.req_alu_flags = 4'hF;
    stable_b = 1'b1;
    first_b  = 1'b1;
    bitv     = 1'b1;
    for (int i = 0; i < 55; i++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (i == 0 && j == 0) first_b = ifb.sout;
        if (j == 0) bitv = ifb.sout;
        else if (ifb.sout !== bitv) stable_b = 1'b0;
      end
      bits[54 - i] = bitv;
    end
    chk("b_start_low", 64'(first_b), 64'd0);
    chk("b_bits", 64'(bits), 64'(EXP_12345678));
    chk("b_bit_stable", 64'(stable_b), 64'd1);
    k = 0;
    while (!ifb.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b_ready_delay", 64'(k), 64'd2);

    // Reset in the middle of the third data packet
    xfer_a(1'b0, 32'h0000_0001, 4'b0000, 3'b000, 1'b0);
    repeat (27) @(negedge clk);
    chk("pre_rst_sout_low", 64'(ifa.sout), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sout", 64'(ifa.sout), 64'd1);
    chk("mid_rst_ready", 64'(ifa.req_ready), 64'd0);
    chk("mid_rst_busy", 64'(ifa.busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("hold_rst_ready", 64'(ifa.req_ready), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rst_ready", 64'(ifa.req_ready), 64'd1);
    chk("rel_rst_sout", 64'(ifa.sout), 64'd1);
    xfer_a(1'b0, 32'h1234_5678, 4'b0000, 3'b000, 1'b0);
    cap_a(55, bits, busy_c, rdy_c, idle_ok);
    chk("post_rst_bits", 64'(bits), 64'(EXP_12345678));
    chk("post_rst_ready_cyc", 64'(rdy_c), 64'd57);

    // Back-to-back with valid held and inputs changed while the first is in flight
    xfer_a(1'b1, 32'h0000_0000, 4'b0000, 3'b001, 1'b1);
    ifa.req_error = 1'b0; ifa.req_c = 32'h0000_0001;
    ifa.req_alu_flags = 4'b0000; ifa.req_err_flags = 3'b110;
    cap_a(11, bits, busy_c, rdy_c, idle_ok);
    chk("b2b_first_bits", 64'(bits[54:44]), 64'(EXP_ERR001));
    chk("b2b_first_ready_cyc", 64'(rdy_c), 64'd13);
    chk("b2b_gap_idle", 64'(idle_ok), 64'd1);
    xfer_a(1'b0, 32'h0000_0001, 4'b0000, 3'b110, 1'b0);
    cap_a(55, bits, busy_c, rdy_c, idle_ok);
    chk("b2b_second_bits", 64'(bits), 64'(EXP_ONE));
    chk("b2b_second_ready_cyc", 64'(rdy_c), 64'd57);

    // Randomized responses decoded against the framing model
    for (int n = 0; n < 1000; n++) begin
      r_err = ($urandom_range(0, 3) == 0);
      r_c   = $urandom;
      r_fl  = 4'($urandom_range(0, 15));
      r_ef  = 3'($urandom_range(0, 7));
      xfer_a(r_err, r_c, r_fl, r_ef, 1'b0);
      if (r_err) begin
        cap_a(11, bits, busy_c, rdy_c, idle_ok);
        chk("rnd_err_bits", 64'(bits[54:44]),
            64'(frm(1'b1, {1'b1, r_ef, r_ef, ^{1'b1, r_ef, r_ef}})));
      end else begin
        exp_bits = {frm(1'b0, r_c[31:24]), frm(1'b0, r_c[23:16]), frm(1'b0, r_c[15:8]),
                    frm(1'b0, r_c[7:0]), frm(1'b1, {1'b0, r_fl, crc3_calc(r_c, r_fl)})};
        cap_a(55, bits, busy_c, rdy_c, idle_ok);
        chk("rnd_res_bits", 64'(bits), 64'(exp_bits));
        chk("rnd_crc", 64'(bits[3:1]), 64'(crc3_calc(r_c, r_fl)));
      end
      chk("rnd_idle", 64'(idle_ok), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 Parameter BIT_CYCLES, default 1, SHALL set the number of clk cycles each serial bit is held on sout (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  response request present.
REQ-005 req_ready  output  1  serializer can accept a request.
REQ-006 req_error  input  1  1 = send error packet; 0 = send result (4 data packets + control packet).
REQ-007 req_c  input  32  ALU result C.
REQ-008 req_alu_flags  input  4  {carry, overflow, zero, negative}.
REQ-009 req_err_flags  input  3  {ERR_DATA, ERR_CRC, ERR_OP}.
REQ-010 sout  output  1  serial output line, idle high.
REQ-011 busy  output  1  high while a response is being transmitted.

Function
REQ-012 Transfer SHALL occur in a cycle where req_valid and req_ready are both high; all req_* inputs SHALL be captured into internal registers in that cycle.
REQ-013 req_ready SHALL be high only in state IDLE; busy SHALL equal the inverse of req_ready out of reset.
REQ-014 States SHALL be IDLE, SEND and DONE; IDLE->SEND on transfer, SEND->DONE after the last stop bit's final cycle, DONE->IDLE unconditionally after one cycle.
REQ-015 The start bit of the first packet SHALL appear on sout in the cycle after transfer.
REQ-016 Each packet SHALL be 11 bits: start 0, type bit (0 data, 1 cmd), 8 payload bits MSB first, stop 1.
REQ-017 Packets within one response SHALL be back-to-back with no idle bits between them.
REQ-018 Result response SHALL be data packets for C[31:24], C[23:16], C[15:8], C[7:0], then a cmd packet with payload {0, alu_flags[3:0], crc3[2:0]}: 55 bits total.
REQ-019 crc3 SHALL be the CRC of the 37-bit message {C[31:0], 1'b0, alu_flags[3:0]} sent MSB first, polynomial x^3+x+1, initial value 0, no reflection, no final XOR.
REQ-020 Error response SHALL be one cmd packet with payload {1, err_flags[2:0], err_flags[2:0], parity}: 11 bits total.
REQ-021 parity SHALL be the XOR of the 7 bits {1'b1, err_flags, err_flags}.
REQ-022 A bit-cycle counter SHALL hold each bit for exactly BIT_CYCLES clocks; a bit counter (0..54) and packet counter (0..4) SHALL select the current bit.
REQ-023 Input changes on req_* after transfer SHALL NOT affect the response in flight.
REQ-024 req_valid asserted while not ready SHALL be ignored (no queuing); the requester holds it until req_ready.
REQ-025 In DONE and IDLE sout SHALL be 1; minimum gap between consecutive responses is 2 idle-high cycles (DONE plus transfer cycle).

Reset
REQ-026 While rst_n is low: state IDLE, sout=1, req_ready=0, busy=0, all counters and captured registers 0.
REQ-027 req_ready SHALL rise in the first clk cycle after rst_n deasserts.
REQ-028 Reset asserted mid-response SHALL force sout to 1 immediately (asynchronously) and abandon the response; no partial packet resumes after reset.

Structure
REQ-029 Shared package SHALL hold: packet-type enum (DATA/CMD), ERR_* and FLAG_* constants, serializer state enum, and a function computing crc3 from C and flags, reused by the bench scoreboard.
REQ-030 One sub-module alu_tx_bit_timer (BIT_CYCLES counter emitting a one-cycle bit_tick) SHALL be used; CRC and framing stay in the top module.

Verification
REQ-031 Result C=0x00000000, flags=4'b0010, BIT_CYCLES=1 -> crc3=3'b110, control payload 0x16; sout: 4×{0,0,0x00,1} then {0,1,0x16,1}; req_ready high again 57 cycles after transfer.
REQ-032 Error, err_flags=3'b001 -> single packet {0,1,0x93,1}; busy high exactly 12 cycles.
REQ-033 Result C=0x12345678, BIT_CYCLES=4 -> payload bytes 0x12,0x34,0x56,0x78 then control; each bit stable for exactly 4 clocks; sout low in cycle after transfer.
REQ-034 rst_n driven low during the 3rd data packet -> sout=1 same cycle, req_ready=0 during reset, 1 one cycle after release; next request sends a complete, correct response.
REQ-035 Back-to-back requests with req_valid held high and req_* changed mid-flight -> first response matches values at first transfer; second starts after exactly 2 idle-high cycles.
REQ-036 Random C/flags, 1000 transfers -> bench receiver decodes every response and crc3 matches the package function.
